// File: rtl/score_keeper_pkg.sv
// Shared constants and types for the score path: score width, BCD layout, bird column,
// and conversion FSM states.
package score_keeper_pkg;

  localparam int unsigned SCORE_W = 10;
  localparam int unsigned BCD_DIG = 4;
  localparam logic [8:0]  PASS_X  = 9'd100;
  localparam int unsigned TICK_HZ = 50;
  localparam logic [8:0]  X_INIT  = 9'h1FF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } conv_state_e;

  // Double-dabble correction applied to one BCD nibble before each shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads bin, then BIN_W cycles of adjust-and-shift.
// done is high during the cycle whose closing edge performs the final shift.
module bin2bcd_seq
  import score_keeper_pkg::*;
#(
  parameter int unsigned BIN_W  = SCORE_W,
  parameter int unsigned DIGITS = BCD_DIG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = dabble_adj(bcd_q[4*i +: 4]);
    end
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(BIN_W);
    end else if (cnt_q != '0) begin
      bcd_d = {bcd_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = (cnt_q == CNT_W'(1)) && !start;

endmodule

// File: rtl/score_keeper.sv
// Counts pillar crossings, tracks the high score, and publishes both as packed BCD
// through a snapshot/convert/commit FSM so the display never sees a partial value.
module score_keeper
  import score_keeper_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   game_active,
  input  logic                   lost,
  input  logic [8:0]             pillar1,
  input  logic [8:0]             pillar2,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     high_score,
  output logic [4*BCD_DIG-1:0]   score_bcd,
  output logic [4*BCD_DIG-1:0]   high_bcd,
  output logic                   bcd_valid,
  output logic                   new_high
);

  localparam int unsigned SUM_W = SCORE_W + 1;

  logic                 ga_q, lost_q;
  logic [8:0]           prev1_q, prev1_d, prev2_q, prev2_d;
  logic [SCORE_W-1:0]   score_q, score_d, high_q, high_d;
  logic                 new_high_q, new_high_d;
  logic [SCORE_W-1:0]   score_last_q, high_last_q;

  logic                 round_start, lost_rise, play, cross1, cross2;
  logic [1:0]           inc;
  logic [SUM_W-1:0]     sum;

  conv_state_e          state_q, state_d;
  logic                 pending_q, pending_d;
  logic                 bcd_valid_q, bcd_valid_d;
  logic [4*BCD_DIG-1:0] score_bcd_q, score_bcd_d, high_bcd_q, high_bcd_d;
  logic                 chg, conv_start, score_done, high_done, conv_done;
  logic [4*BCD_DIG-1:0] score_conv, high_conv;

  always_comb begin
    round_start = game_active & ~ga_q;
    lost_rise   = lost & ~lost_q;
    play        = tick & game_active & ~lost;
    cross1      = (prev1_q > PASS_X) && (pillar1 <= PASS_X);
    cross2      = (prev2_q > PASS_X) && (pillar2 <= PASS_X);
    inc         = play ? ({1'b0, cross1} + {1'b0, cross2}) : 2'd0;
    sum         = {1'b0, score_q} + SUM_W'(inc);

    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    prev1_d    = prev1_q;
    prev2_d    = prev2_q;

    if (round_start) begin
      score_d    = '0;
      new_high_d = 1'b0;
    end else begin
      score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      if (lost_rise && (score_q > high_q)) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end
    end

    if (tick) begin
      prev1_d = pillar1;
      prev2_d = pillar2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ga_q         <= 1'b0;
      lost_q       <= 1'b0;
      prev1_q      <= X_INIT;
      prev2_q      <= X_INIT;
      score_q      <= '0;
      high_q       <= '0;
      new_high_q   <= 1'b0;
      score_last_q <= '0;
      high_last_q  <= '0;
    end else begin
      ga_q         <= game_active;
      lost_q       <= lost;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      score_q      <= score_d;
      high_q       <= high_d;
      new_high_q   <= new_high_d;
      score_last_q <= score_q;
      high_last_q  <= high_q;
    end
  end

  // chg flags any edge that altered either binary value; pending remembers one seen mid-conversion.
  assign chg       = (score_q != score_last_q) || (high_q != high_last_q);
  assign conv_done = score_done & high_done;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    bcd_valid_d = bcd_valid_q;
    score_bcd_d = score_bcd_q;
    high_bcd_d  = high_bcd_q;
    conv_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (chg || pending_q) begin
          conv_start  = 1'b1;
          pending_d   = 1'b0;
          bcd_valid_d = 1'b0;
          state_d     = S_CONV;
        end
      end
      S_CONV: begin
        if (chg) pending_d = 1'b1;
        if (conv_done) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (chg || pending_q) begin
          pending_d = 1'b1;
        end else begin
          score_bcd_d = score_conv;
          high_bcd_d  = high_conv;
          bcd_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      bcd_valid_q <= 1'b1;
      score_bcd_q <= '0;
      high_bcd_q  <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      bcd_valid_q <= bcd_valid_d;
      score_bcd_q <= score_bcd_d;
      high_bcd_q  <= high_bcd_d;
    end
  end

  bin2bcd_seq #(
    .BIN_W  (SCORE_W),
    .DIGITS (BCD_DIG)
  ) u_score_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (score_q),
    .bcd   (score_conv),
    .done  (score_done)
  );

  bin2bcd_seq #(
    .BIN_W  (SCORE_W),
    .DIGITS (BCD_DIG)
  ) u_high_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (high_q),
    .bcd   (high_conv),
    .done  (high_done)
  );

  assign score      = score_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;
  assign score_bcd  = score_bcd_q;
  assign high_bcd   = high_bcd_q;
  assign bcd_valid  = bcd_valid_q & ~chg & ~pending_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, directed corner sequences,
// and random play against an integer reference model.
module tb_score_keeper;
  import score_keeper_pkg::*;

  localparam int BW = 4 * BCD_DIG;

  logic clk = 1'b0;
  logic rst, tick, game_active, lost;
  logic [8:0] pillar1, pillar2;
  logic [SCORE_W-1:0] score, high_score;
  logic [BW-1:0] score_bcd, high_bcd;
  logic bcd_valid, new_high;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_score, m_high, m_nh, m_p1, m_p2, m_ga, m_lost, since;
  bit chk_model = 1'b0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .game_active (game_active),
    .lost        (lost),
    .pillar1     (pillar1),
    .pillar2     (pillar2),
    .score       (score),
    .high_score  (high_score),
    .score_bcd   (score_bcd),
    .high_bcd    (high_bcd),
    .bcd_valid   (bcd_valid),
    .new_high    (new_high)
  );

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < BCD_DIG; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    int add, os, oh;
    os = m_score;
    oh = m_high;
    if (rst) begin
      m_score = 0; m_high = 0; m_nh = 0; m_p1 = 511; m_p2 = 511;
      m_ga = 0; m_lost = 0; since = 1000;
    end else begin
      add = 0;
      if (tick && game_active && !lost) begin
        if (m_p1 > int'(PASS_X) && int'(pillar1) <= int'(PASS_X)) add++;
        if (m_p2 > int'(PASS_X) && int'(pillar2) <= int'(PASS_X)) add++;
      end
      if (game_active && m_ga == 0) begin
        m_score = 0;
        m_nh = 0;
      end else begin
        if (lost && m_lost == 0 && m_score > m_high) begin
          m_high = m_score;
          m_nh = 1;
        end
        m_score = (os + add > 1023) ? 1023 : os + add;
      end
      if (tick) begin
        m_p1 = int'(pillar1);
        m_p2 = int'(pillar2);
      end
      m_ga = int'(game_active);
      m_lost = int'(lost);
      if (m_score != os || m_high != oh) since = 0;
      else if (since < 1000) since++;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (bcd_valid === 1'b1) begin
      check("score_bcd_when_valid", 32'(score_bcd), 32'(to_bcd(m_score)));
      check("high_bcd_when_valid", 32'(high_bcd), 32'(to_bcd(m_high)));
    end
    if (since < 12) check("bcd_valid_low_after_change", 32'(bcd_valid), 0);
    if (since >= 24) check("bcd_valid_settled", 32'(bcd_valid), 1);
    if (chk_model) begin
      check("score_model", 32'(score), m_score);
      check("high_model", 32'(high_score), m_high);
      check("new_high_model", 32'(new_high), m_nh);
    end
  endtask

  task automatic do_tick(input int p1, input int p2);
    tick = 1'b1;
    pillar1 = 9'(p1);
    pillar2 = 9'(p2);
    step();
    tick = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_score", 32'(score), 0);
    check("rst_high", 32'(high_score), 0);
    check("rst_score_bcd", 32'(score_bcd), 0);
    check("rst_high_bcd", 32'(high_bcd), 0);
    check("rst_bcd_valid", 32'(bcd_valid), 1);
    check("rst_new_high", 32'(new_high), 0);
  endtask

  task automatic do_reset_and_start();
    rst = 1'b1; game_active = 1'b0; lost = 1'b0; tick = 1'b0;
    step();
    rst = 1'b0;
    step();
    game_active = 1'b1;
    step();
  endtask

  typedef struct {
    int tk, ga, ls, p1, p2, s, h, nh;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int cnt, rp1, rp2;

    rst = 1'b1; tick = 1'b0; game_active = 1'b0; lost = 1'b0;
    pillar1 = 9'd0; pillar2 = 9'd0;

    // reset values
    step();
    step();
    check_reset_values();
    rst = 1'b0;
    step();

    // vector table: one row per clock, expectations after the edge
    tbl[0]  = '{0, 1, 0, 200, 300, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 102, 300, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 102, 300, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 101, 300, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 100, 300, 1, 0, 0};
    tbl[5]  = '{1, 1, 0, 101, 105, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 100,  99, 3, 0, 0};
    tbl[7]  = '{1, 1, 0,   3,  50, 3, 0, 0};
    tbl[8]  = '{1, 1, 0, 400,  60, 3, 0, 0};
    tbl[9]  = '{1, 1, 0, 390, 300, 3, 0, 0};
    tbl[10] = '{0, 1, 0, 100, 100, 3, 0, 0};
    tbl[11] = '{1, 1, 1, 100, 100, 3, 3, 1};
    tbl[12] = '{1, 1, 1,  90,  90, 3, 3, 1};
    tbl[13] = '{1, 1, 0, 300, 300, 3, 3, 1};
    tbl[14] = '{1, 1, 0, 100, 300, 4, 3, 1};
    tbl[15] = '{1, 0, 0, 300, 300, 4, 3, 1};
    tbl[16] = '{1, 1, 0, 100, 100, 0, 3, 0};
    tbl[17] = '{1, 1, 0,  99, 100, 0, 3, 0};
    for (int i = 0; i < 18; i++) begin
      tick = tbl[i].tk[0];
      game_active = tbl[i].ga[0];
      lost = tbl[i].ls[0];
      pillar1 = tbl[i].p1[8:0];
      pillar2 = tbl[i].p2[8:0];
      step();
      check($sformatf("tbl%0d_score", i), 32'(score), tbl[i].s);
      check($sformatf("tbl%0d_high", i), 32'(high_score), tbl[i].h);
      check($sformatf("tbl%0d_new_high", i), 32'(new_high), tbl[i].nh);
    end
    tick = 1'b0; lost = 1'b0;

    // first point and exact BCD commit latency
    do_reset_and_start();
    do_tick(102, 300);
    do_tick(101, 300);
    do_tick(100, 300);
    check("lat_score", 32'(score), 1);
    check("lat_valid_at_change", 32'(bcd_valid), 0);
    repeat (11) step();
    check("lat_valid_at_11", 32'(bcd_valid), 0);
    step();
    check("lat_valid_at_12", 32'(bcd_valid), 1);
    check("lat_bcd_at_12", 32'(score_bcd), 32'h0001);

    // saturation
    do_reset_and_start();
    for (int i = 0; i < 511; i++) begin
      do_tick(101, 101);
      do_tick(100, 100);
    end
    check("sat_1022", 32'(score), 1022);
    do_tick(101, 101);
    do_tick(100, 100);
    check("sat_1023", 32'(score), 1023);
    repeat (24) step();
    check("sat_bcd", 32'(score_bcd), 32'h1023);
    check("sat_valid", 32'(bcd_valid), 1);
    do_tick(101, 101);
    do_tick(100, 100);
    check("sat_hold", 32'(score), 1023);

    // high score and round restart
    do_reset_and_start();
    for (int i = 0; i < 10; i++) begin
      do_tick(101, 101);
      do_tick(100, 100);
    end
    check("hs_score20", 32'(score), 20);
    lost = 1'b1;
    step();
    check("hs_high20", 32'(high_score), 20);
    check("hs_nh20", 32'(new_high), 1);
    lost = 1'b0; game_active = 1'b0;
    step();
    game_active = 1'b1;
    step();
    check("hs_round_score", 32'(score), 0);
    check("hs_round_nh", 32'(new_high), 0);
    for (int i = 0; i < 18; i++) begin
      do_tick(101, 101);
      do_tick(100, 100);
    end
    do_tick(101, 300);
    do_tick(100, 300);
    check("hs_score37", 32'(score), 37);
    lost = 1'b1;
    step();
    check("hs_high37", 32'(high_score), 37);
    check("hs_nh37", 32'(new_high), 1);
    repeat (24) step();
    check("hs_high_bcd", 32'(high_bcd), 32'h0037);
    check("hs_score_bcd", 32'(score_bcd), 32'h0037);
    lost = 1'b0; game_active = 1'b0;
    step();
    game_active = 1'b1;
    step();
    check("hs_new_round_score", 32'(score), 0);
    check("hs_new_round_nh", 32'(new_high), 0);
    check("hs_new_round_high", 32'(high_score), 37);

    // change arriving mid-conversion must suppress the stale commit
    do_tick(101, 101);
    repeat (24) step();
    do_tick(100, 101);
    repeat (5) step();
    do_tick(100, 100);
    check("stale_score", 32'(score), 2);
    cnt = 0;
    while (bcd_valid !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    check("stale_low_window", 32'(cnt >= 12), 1);
    check("stale_settles", 32'(cnt < 40), 1);
    check("stale_final_bcd", 32'(score_bcd), 32'h0002);

    // reset in the middle of a conversion
    do_tick(101, 101);
    do_tick(100, 100);
    repeat (4) step();
    rst = 1'b1;
    step();
    check_reset_values();
    rst = 1'b0;

    // random play against the model
    do_reset_and_start();
    chk_model = 1'b1;
    rp1 = 300; rp2 = 450;
    for (int n = 0; n < 3000; n++) begin
      tick = ($urandom_range(0, 2) == 0);
      if (tick) begin
        rp1 = rp1 - int'($urandom_range(0, 3));
        rp2 = rp2 - int'($urandom_range(0, 3));
        if (rp1 < 5) rp1 = int'($urandom_range(300, 511));
        if (rp2 < 5) rp2 = int'($urandom_range(300, 511));
      end
      pillar1 = 9'(rp1);
      pillar2 = 9'(rp2);
      if ($urandom_range(0, 299) == 0) begin
        game_active = ~game_active;
        if (!game_active) lost = 1'b0;
      end else if (game_active && !lost && $urandom_range(0, 199) == 0) begin
        lost = 1'b1;
      end
      step();
    end
    chk_model = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
